// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage with a single outstanding imem read and a one-entry output slot.
module if_fetch #(
  parameter logic [31:0] reset_pc = 32'h0000_0000,
  parameter logic [31:0] nop_inst = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state, state_nxt;
  logic [31:0] pc, req_addr;
  logic consume, slot_free;
  assign consume = if_valid & ~pause;
  assign slot_free = ~if_valid | consume;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // redirect during WAIT still owes one response, which DROP swallows
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = (imem_req & imem_gnt) ? WAIT : IDLE;
      WAIT: state_nxt = imem_rvalid ? IDLE : redirect ? DROP : WAIT;
      DROP: state_nxt = imem_rvalid ? IDLE : DROP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    imem_req = ~rst & (state == IDLE) & slot_free & ~redirect;
    imem_addr = pc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= reset_pc;
      req_addr <= reset_pc;
      if_pc <= reset_pc;
      if_inst <= nop_inst;
      if_valid <= 1'b0;
    end else begin
      if (imem_req & imem_gnt) req_addr <= pc;
      if (redirect) begin
        pc <= {redirect_pc[31:2], 2'b00};
        if_valid <= 1'b0;
        if_inst <= nop_inst;
      end else if (state == WAIT && imem_rvalid) begin
        pc <= req_addr + 32'd4;
        if_pc <= req_addr;
        if_inst <= imem_rdata;
        if_valid <= 1'b1;
      end else if (consume) begin
        if_valid <= 1'b0;
        if_inst <= nop_inst;
      end
    end
endmodule
